// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/busy/done handshake, iterative 1-bit/cycle shifter
// and an optional iterative shift-add multiplier enabled by defining ALU_MUL_EN.
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alucontrol,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
`endif

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t          state, state_nxt;
    logic [XLEN-1:0] acc, acc_nxt;
    logic [SHW-1:0]  cnt, cnt_nxt;
    logic [3:0]      op_q, op_nxt;
    logic [XLEN-1:0] result_nxt;
    logic            done_nxt;
    logic [XLEN-1:0] alu_val;
    logic [SHW-1:0]  shamt;
    logic            is_shift;
`ifdef ALU_MUL_EN
    logic [XLEN-1:0] mcand, mcand_nxt;
    logic [XLEN-1:0] mplier, mplier_nxt;
    logic [XLEN-1:0] mstep;
`endif

    function automatic logic [XLEN-1:0] shift1(input logic [3:0] op, input logic [XLEN-1:0] v);
        case (op)
            OP_SLL:  shift1 = {v[XLEN-2:0], 1'b0};
            OP_SRL:  shift1 = {1'b0, v[XLEN-1:1]};
            default: shift1 = {v[XLEN-1], v[XLEN-1:1]};
        endcase
    endfunction

    assign shamt    = b[SHW-1:0];
    assign is_shift = (alucontrol == OP_SLL) || (alucontrol == OP_SRL) || (alucontrol == OP_SRA);
    assign busy     = (state != IDLE);

    // Single-cycle results; shifts land here only when shamt is 0 or 1.
    always_comb begin
        alu_val = '0;
        case (alucontrol)
            OP_ADD:  alu_val = a + b;
            OP_SUB:  alu_val = a - b;
            OP_AND:  alu_val = a & b;
            OP_OR:   alu_val = a | b;
            OP_XOR:  alu_val = a ^ b;
            OP_SLT:  alu_val = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_val = {{(XLEN-1){1'b0}}, a < b};
            OP_SLL, OP_SRL, OP_SRA:
                     alu_val = (shamt == '0) ? a : shift1(alucontrol, a);
            default: alu_val = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    assign mstep = mplier[0] ? mcand : '0;
`endif

    // The first shift/multiply step is taken on the accept edge, so an
    // n-step op reports done n cycles after it was accepted.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        op_nxt     = op_q;
        result_nxt = result;
        done_nxt   = 1'b0;
`ifdef ALU_MUL_EN
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    op_nxt = alucontrol;
                    if (is_shift && shamt > SHW'(1)) begin
                        acc_nxt   = shift1(alucontrol, a);
                        cnt_nxt   = shamt - SHW'(1);
                        state_nxt = SHIFT;
`ifdef ALU_MUL_EN
                    end else if (alucontrol == OP_MUL) begin
                        acc_nxt    = b[0] ? a : '0;
                        mcand_nxt  = {a[XLEN-2:0], 1'b0};
                        mplier_nxt = {1'b0, b[XLEN-1:1]};
                        cnt_nxt    = SHW'(XLEN-1);
                        state_nxt  = MUL;
`endif
                    end else begin
                        result_nxt = alu_val;
                        done_nxt   = 1'b1;
                    end
                end
            end
            SHIFT: begin
                acc_nxt = shift1(op_q, acc);
                cnt_nxt = cnt - SHW'(1);
                if (cnt == SHW'(1)) begin
                    result_nxt = shift1(op_q, acc);
                    done_nxt   = 1'b1;
                    state_nxt  = IDLE;
                end
            end
`ifdef ALU_MUL_EN
            MUL: begin
                acc_nxt    = acc + mstep;
                mcand_nxt  = {mcand[XLEN-2:0], 1'b0};
                mplier_nxt = {1'b0, mplier[XLEN-1:1]};
                cnt_nxt    = cnt - SHW'(1);
                if (cnt == SHW'(1)) begin
                    result_nxt = acc + mstep;
                    done_nxt   = 1'b1;
                    state_nxt  = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            op_q   <= '0;
            result <= '0;
            zero   <= 1'b1;
            done   <= 1'b0;
`ifdef ALU_MUL_EN
            mcand  <= '0;
            mplier <= '0;
`endif
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            op_q   <= op_nxt;
            result <= result_nxt;
            zero   <= ~|result_nxt;
            done   <= done_nxt;
`ifdef ALU_MUL_EN
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: latency, busy window, result/zero,
// start-while-busy, reset abort and back-to-back ops.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a, b;
    logic [3:0]  alucontrol;
    logic        busy, done, zero;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;

    alu_seq #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .alucontrol(alucontrol), .busy(busy), .done(done),
        .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, wait for done, check latency, busy window, result, zero
    // and that done drops again on the following cycle.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] exp, input int exp_lat);
        int lat;
        logic busy_ok;
        @(negedge clk);
        start = 1'b1; alucontrol = op; a = va; b = vb;
        @(posedge clk); #1;
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0; alucontrol = 4'b0000;
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!done && !busy) busy_ok = 1'b0;
        end while (!done && lat < 100);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy window"}, {31'b0, busy_ok & ~busy}, 32'd1);
        chk({tag, " result"}, result, exp);
        chk({tag, " zero"}, {31'b0, zero}, {31'b0, exp == 32'h0});
        @(negedge clk);
        chk({tag, " done pulse"}, {31'b0, done}, 32'd0);
        chk({tag, " result hold"}, result, exp);
    endtask

    initial begin
        int dones, dcyc;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; alucontrol = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset result", result, 32'h0);
        chk("reset zero", {31'b0, zero}, 32'd1);
        chk("reset busy/done", {30'b0, busy, done}, 32'd0);
        @(negedge clk) reset = 1'b0;

        run_op("ADD",  4'b0000, 32'd5, 32'd7, 32'd12, 1);
        run_op("SUB",  4'b0001, 32'd7, 32'd7, 32'd0, 1);
        run_op("SLT",  4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op("SLTU", 4'b0110, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_op("XOR",  4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
        run_op("AND",  4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
        run_op("OR",   4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1);
        run_op("ADDW", 4'b0000, 32'hFFFF_FFFF, 32'd2, 32'd1, 1);
        run_op("SRA4", 4'b1001, 32'h8000_0000, 32'd4, 32'hF800_0000, 4);
        run_op("SRL4", 4'b1000, 32'h8000_0000, 32'd4, 32'h0800_0000, 4);
        run_op("SLL0", 4'b0111, 32'd1, 32'd0, 32'd1, 1);
        run_op("SRL1", 4'b1000, 32'h8000_0000, 32'd1, 32'h4000_0000, 1);
        run_op("BAD",  4'b1111, 32'd3, 32'd4, 32'd0, 1);
        run_op("ADD2", 4'b0000, 32'd1, 32'd1, 32'd2, 1);
`ifdef ALU_MUL_EN
        run_op("MUL",  4'b1010, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 32);
        run_op("MUL0", 4'b1010, 32'h0, 32'h1234_5678, 32'h0, 32);
`else
        run_op("MULX", 4'b1010, 32'h0000_FFFF, 32'h0001_0001, 32'h0, 1);
`endif

        // Start while busy must be ignored.
        @(negedge clk);
        start = 1'b1; alucontrol = 4'b0111; a = 32'd1; b = 32'd31;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; alucontrol = 4'b0000; a = 32'd5; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0; dcyc = 0;
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin dones++; dcyc = c; end
        end
        chk("busy-ignore dones", dones, 32'd1);
        chk("busy-ignore cycle", dcyc, 32'd31);
        chk("busy-ignore result", result, 32'h8000_0000);

        // Reset mid-shift abandons the op.
        @(negedge clk);
        start = 1'b1; alucontrol = 4'b0111; a = 32'd1; b = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-reset busy", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort result", result, 32'h0);
        chk("abort zero", {31'b0, zero}, 32'd1);
        dones = 0;
        repeat (2) @(negedge clk) if (done) dones++;
        reset = 1'b0;
        repeat (12) @(negedge clk) if (done) dones++;
        chk("abort no done", dones, 32'd0);
        run_op("post-reset ADD", 4'b0000, 32'd5, 32'd7, 32'd12, 1);

        // Back-to-back single-cycle ops give done every cycle.
        @(negedge clk);
        start = 1'b1; alucontrol = 4'b0000; a = 32'd20; b = 32'd22;
        @(posedge clk); #1;
        alucontrol = 4'b0001; a = 32'd9; b = 32'd9;
        @(negedge clk);
        chk("b2b done1", {31'b0, done}, 32'd1);
        chk("b2b result1", result, 32'd42);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b done2", {31'b0, done}, 32'd1);
        chk("b2b result2", result, 32'd0);
        chk("b2b zero2", {31'b0, zero}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
